// File: rtl/btn_frontend_seg7.sv
// Button front end: per-channel metastability synchronizer, rising-edge pulse
// generator, and an active-low hex-to-seven-segment decoder (0xF blanks).
module btn_frontend_seg7 #(
   parameter int N_BTN       = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] key_n,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   input  logic [3:0]       hex_val,
   output logic [6:0]       seg
);

   // Stage-major packing: each row holds one synchronizer stage for all channels.
   logic [SYNC_STAGES-1:0][N_BTN-1:0] r_sync;
   logic [N_BTN-1:0]                  r_prev;
   logic [N_BTN-1:0]                  w_raw;

   assign w_raw = ~key_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign btn_level = r_sync[SYNC_STAGES-1];
   assign btn_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

   always_comb begin
      seg = 7'h7F;
      case (hex_val)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: tb/tb_btn_frontend_seg7.sv
// Directed bench for btn_frontend_seg7 with the default two channels and two
// synchronizer stages; outputs are sampled 1 time unit after each rising edge.
module tb_btn_frontend_seg7;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_n;
   logic [1:0] btn_level;
   logic [1:0] btn_pulse;
   logic [3:0] hex_val;
   logic [6:0] seg;

   int checks = 0;
   int errors = 0;

   btn_frontend_seg7 #(.N_BTN(2), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_n     (key_n),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .hex_val   (hex_val),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      key_n   = 2'b11;
      hex_val = 4'h0;
      #1;
      checks++;
      if (btn_level !== 2'b00) begin
         errors++;
         $display("FAIL reset_level got %b want 00", btn_level);
      end
      checks++;
      if (btn_pulse !== 2'b00) begin
         errors++;
         $display("FAIL reset_pulse got %b want 00", btn_pulse);
      end
      checks++;
      if (seg !== 7'h40) begin
         errors++;
         $display("FAIL reset_seg got %h want 40", seg);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (btn_level !== 2'b00 || btn_pulse !== 2'b00) begin
            errors++;
            $display("FAIL idle cyc %0d got lvl %b pls %b want 00 00", c, btn_level, btn_pulse);
         end
      end
   endtask

   // Single-edge press on channel 0: level/pulse high only after the second edge.
   task automatic test_short_press();
      logic [1:0] exp_lvl [4];
      logic [1:0] exp_pls [4];
      exp_lvl = '{2'b00, 2'b01, 2'b00, 2'b00};
      exp_pls = '{2'b00, 2'b01, 2'b00, 2'b00};
      key_n = 2'b10;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0) key_n = 2'b11;
         checks++;
         if (btn_level !== exp_lvl[c]) begin
            errors++;
            $display("FAIL short_level cyc %0d got %b want %b", c, btn_level, exp_lvl[c]);
         end
         checks++;
         if (btn_pulse !== exp_pls[c]) begin
            errors++;
            $display("FAIL short_pulse cyc %0d got %b want %b", c, btn_pulse, exp_pls[c]);
         end
      end
   endtask

   task automatic test_long_press();
      logic [6:0] lvl_pat;
      logic [6:0] pls_pat;
      lvl_pat = 7'b0011110;
      pls_pat = 7'b0000010;
      key_n = 2'b10;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (c == 3) key_n = 2'b11;
         checks++;
         if (btn_level !== {1'b0, lvl_pat[c]}) begin
            errors++;
            $display("FAIL long_level cyc %0d got %b want 0%b", c, btn_level, lvl_pat[c]);
         end
         checks++;
         if (btn_pulse !== {1'b0, pls_pat[c]}) begin
            errors++;
            $display("FAIL long_pulse cyc %0d got %b want 0%b", c, btn_pulse, pls_pat[c]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_lvl [6];
      logic [1:0] exp_pls [6];
      exp_lvl = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      exp_pls = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      key_n = 2'b00;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c == 2) key_n = 2'b11;
         checks++;
         if (btn_level !== exp_lvl[c]) begin
            errors++;
            $display("FAIL simul_level cyc %0d got %b want %b", c, btn_level, exp_lvl[c]);
         end
         checks++;
         if (btn_pulse !== exp_pls[c]) begin
            errors++;
            $display("FAIL simul_pulse cyc %0d got %b want %b", c, btn_pulse, exp_pls[c]);
         end
      end
   endtask

   // Channel 1 held; reset lands while its pulse is high, then a fresh pulse follows.
   task automatic test_reset_mid_hold();
      key_n   = 2'b01;
      hex_val = 4'h2;
      tick();
      tick();
      checks++;
      if (btn_level !== 2'b10 || btn_pulse !== 2'b10) begin
         errors++;
         $display("FAIL rmh_pre got lvl %b pls %b want 10 10", btn_level, btn_pulse);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (btn_level !== 2'b00 || btn_pulse !== 2'b00) begin
         errors++;
         $display("FAIL rmh_async got lvl %b pls %b want 00 00", btn_level, btn_pulse);
      end
      checks++;
      if (seg !== 7'h24) begin
         errors++;
         $display("FAIL rmh_seg got %h want 24", seg);
      end
      tick();
      checks++;
      if (btn_level !== 2'b00) begin
         errors++;
         $display("FAIL rmh_held got %b want 00", btn_level);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (btn_level !== 2'b00 || btn_pulse !== 2'b00) begin
         errors++;
         $display("FAIL rmh_e1 got lvl %b pls %b want 00 00", btn_level, btn_pulse);
      end
      tick();
      checks++;
      if (btn_level !== 2'b10 || btn_pulse !== 2'b10) begin
         errors++;
         $display("FAIL rmh_e2 got lvl %b pls %b want 10 10", btn_level, btn_pulse);
      end
      tick();
      checks++;
      if (btn_level !== 2'b10 || btn_pulse !== 2'b00) begin
         errors++;
         $display("FAIL rmh_e3 got lvl %b pls %b want 10 00", btn_level, btn_pulse);
      end
      key_n = 2'b11;
      tick();
      tick();
      checks++;
      if (btn_level !== 2'b00 || btn_pulse !== 2'b00) begin
         errors++;
         $display("FAIL rmh_release got lvl %b pls %b want 00 00", btn_level, btn_pulse);
      end
   endtask

   task automatic test_decoder();
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};
      for (int v = 0; v < 16; v++) begin
         hex_val = 4'(v);
         #1;
         checks++;
         if (seg !== tbl[v]) begin
            errors++;
            $display("FAIL dec_%0h got %h want %h", v, seg, tbl[v]);
         end
      end
      reset = 1'b1;
      for (int v = 0; v < 16; v += 5) begin
         hex_val = 4'(v);
         tick();
         checks++;
         if (seg !== tbl[v]) begin
            errors++;
            $display("FAIL dec_rst_%0h got %h want %h", v, seg, tbl[v]);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_press();
      test_simultaneous();
      test_reset_mid_hold();
      test_decoder();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_frontend_seg7.md
# btn_frontend_seg7

Input/output front end for the DE1-SoC tug-of-war top level. It takes N raw active-low push-button inputs and passes each through a multi-flop metastability synchronizer. It then converts each synchronized level into a single-cycle rising-edge pulse for the game core. The block also contains a combinational hex-to-seven-segment decoder that drives one active-low display digit, where code 0xF blanks the digit.

## Interface
Parameters:
- N_BTN, default 2: number of independent button channels.
- SYNC_STAGES, default 2: synchronizer flop depth per channel; legal values are ≥ 2.

Ports:
- clk  input  1  single system clock (CLOCK_50); all state is clocked on its rising edge.
- reset  input  1  asynchronous, active-high; clears all flops immediately, independent of clk.
- key_n  input  N_BTN  raw buttons, active-low (0 = pressed); asynchronous to clk.
- btn_level  output  N_BTN  synchronized, active-high button level per channel.
- btn_pulse  output  N_BTN  one-cycle active-high pulse per press (rising edge of btn_level).
- hex_val  input  4  value to display.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a} (seg[0]=a … seg[6]=g).

## Operation
- Per channel i:
  - raw = ~key_n[i].
  - raw is shifted through a SYNC_STAGES-deep flop chain s[0..SYNC_STAGES-1].
  - btn_level[i] = s[SYNC_STAGES-1].
  - A history flop prev[i] captures btn_level[i] every cycle.
  - btn_pulse[i] = btn_level[i] & ~prev[i], driven combinationally from registered signals only.
- Channels are fully independent; simultaneous presses produce simultaneous pulses.
- Release (falling edge) never produces a pulse.
- Holding a button produces exactly one pulse, no matter how long it is held.
- No debounce filtering. Each clean low-to-high transition of the synchronized level produces one pulse.
- Decoder is purely combinational, hex_val → seg, with active-low values:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06
  - F=0x7F (all segments off, blank)
- The decoder is unaffected by clk and reset.

## Timing
- Reset values: all sync flops = 0, all prev flops = 0, so btn_level = 0 and btn_pulse = 0. seg keeps following hex_val.
- Latency:
  - A press that is stable before rising edge k appears on btn_level after edge k+SYNC_STAGES-1 (edge k+1 with the default of 2).
  - btn_pulse is high during the same cycle that btn_level first goes high.
  - btn_pulse deasserts after the next edge, when prev catches up, giving a pulse width of exactly 1 clk cycle.
- Release latency equals press latency. btn_level falls SYNC_STAGES edges after release.
- Minimum press width: a press must be held across at least one rising edge to be captured. Narrower glitches may be missed.
- Re-press: after a release, the next press pulses again once btn_level has been low for at least 1 cycle (prev = 0).
- Reset asserted mid-press: outputs clear immediately.
  - If the button is still held at reset release, btn_level rises SYNC_STAGES edges later.
  - One pulse is then generated, because prev resets to 0. This is required behaviour.
- Reset asserted while btn_pulse is high truncates the pulse asynchronously.

## Test plan
- Reset, idle: reset=1 for 1 cycle, key_n=all 1s -> btn_level=0 and btn_pulse=0 for 4+ cycles; hex_val=0 -> seg=0x40.
- Short press: key_n[0]=0 for 1 cycle, then 1 (SYNC_STAGES=2) -> btn_level[0] high for 1 cycle, 2 edges after the press was sampled; btn_pulse[0] high for exactly that cycle; channel 1 stays 0.
- Long press: key_n[0]=0 for 4 cycles -> btn_level[0] high for 4 cycles, delayed by 2 edges; exactly one btn_pulse[0] cycle, on the first; no pulse on release.
- Simultaneous presses: key_n=2'b00 for 3 cycles -> btn_pulse=2'b11 in one cycle, then 2'b00.
- Reset mid-hold: hold key_n[1]=0, pulse reset high for 1 cycle -> outputs clear asynchronously; after release, btn_level[1] rises 2 edges later with one pulse.
- Decoder sweep: hex_val 0..F -> seg matches the table; 1->0x79, 2->0x24, F->0x7F; unchanged while reset is high.
